// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StZero
    } state_e;

    localparam int unsigned DefDW = 8;
    localparam int unsigned DefVW = 4;
    localparam int unsigned CntW  = $clog2(DefDW);

    // Iteration counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int unsigned VW = 4
) (
    input  logic [VW:0]   r_i,
    input  logic          q_msb_i,
    input  logic [VW-1:0] d_i,
    output logic [VW:0]   r_o,
    output logic          q_bit_o
);

    logic [VW:0] trial;
    logic [VW:0] d_ext;

    // The incoming remainder is always below the divisor, so its top bit is zero.
    assign trial = {r_i[VW-1:0], q_msb_i};
    assign d_ext = {1'b0, d_i};

    always_comb begin
        q_bit_o = 1'b0;
        r_o     = trial;
        if (trial >= d_ext) begin
            q_bit_o = 1'b1;
            r_o     = trial - d_ext;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with start/done handshake and divide-by-zero flag.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned DW = DefDW,
    parameter int unsigned VW = DefVW
) (
    input  logic          clk_i,
    input  logic          resetn_i,
    input  logic          start_i,
    input  logic [DW-1:0] dividend_i,
    input  logic [VW-1:0] divisor_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [DW-1:0] quotient_o,
    output logic [VW-1:0] remainder_o,
    output logic          div_by_zero_o
);

    localparam int unsigned CW = cnt_width(DW);

    if (VW > DW) begin : g_bad_vw
        $error("seq_divider: VW must not exceed DW");
    end
    if (DW < 2) begin : g_bad_dw
        $error("seq_divider: DW must be at least 2");
    end

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [VW:0]   r_q, r_d;
    logic [DW-1:0] q_q, q_d;
    logic [VW-1:0] d_q, d_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [VW-1:0] rem_q, rem_d;
    logic          dbz_q, dbz_d;
    logic          done_q, done_d;

    logic [VW:0]   step_r;
    logic          step_bit;
    logic [DW-1:0] q_shift;
    logic          last_iter;

    div_step #(
        .VW(VW)
    ) u_step (
        .r_i    (r_q),
        .q_msb_i(q_q[DW-1]),
        .d_i    (d_q),
        .r_o    (step_r),
        .q_bit_o(step_bit)
    );

    assign q_shift   = {q_q[DW-2:0], step_bit};
    assign last_iter = (cnt_q == CW'(DW - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    r_d     = '0;
                    q_d     = dividend_i;
                    d_d     = divisor_i;
                    cnt_d   = '0;
                    state_d = (divisor_i == '0) ? StZero : StRun;
                end
            end
            StRun: begin
                r_d = step_r;
                q_d = q_shift;
                if (last_iter) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    quot_d  = q_shift;
                    rem_d   = step_r[VW-1:0];
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StZero: begin
                state_d = StIdle;
                quot_d  = '1;
                rem_d   = '0;
                dbz_d   = 1'b1;
                done_d  = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    // Busy tracks the registered state, so it drops in the same cycle done rises.
    assign busy_o        = (state_q != StIdle);
    assign done_o        = done_q;
    assign quotient_o    = quot_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive checks for seq_divider in its default 8/4 configuration.
module tb_seq_divider;

    logic       clk;
    logic       resetn;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       dbz;

    int n_checks = 0;
    int n_pass   = 0;

    seq_divider dut (
        .clk_i        (clk),
        .resetn_i     (resetn),
        .start_i      (start),
        .dividend_i   (dividend),
        .divisor_i    (divisor),
        .busy_o       (busy),
        .done_o       (done),
        .quotient_o   (quotient),
        .remainder_o  (remainder),
        .div_by_zero_o(dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] exp_q;
        logic [3:0] exp_r;
        logic       exp_z;
        int         exp_lat;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Issue one operation from idle and wait for done; lat=0 means no done within budget.
    task automatic run_op(input logic [7:0] a, input logic [3:0] b, output int lat,
                          output logic busy_acc);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        busy_acc = busy;
        lat      = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    vec_t vecs[10];
    int   lat;
    logic bacc;
    int   ndone;
    int   exp_qi, exp_ri, exp_zi;

    initial begin
        vecs[0] = '{8'd36,  4'd3,  8'd12,  4'd0, 1'b0, 8};
        vecs[1] = '{8'd225, 4'd15, 8'd15,  4'd0, 1'b0, 8};
        vecs[2] = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 8};
        vecs[3] = '{8'd5,   4'd9,  8'd0,   4'd5, 1'b0, 8};
        vecs[4] = '{8'd0,   4'd1,  8'd0,   4'd0, 1'b0, 8};
        vecs[5] = '{8'h5A,  4'd0,  8'hFF,  4'd0, 1'b1, 1};
        vecs[6] = '{8'd100, 4'd10, 8'd10,  4'd0, 1'b0, 8};
        vecs[7] = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 8};
        vecs[8] = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 8};
        vecs[9] = '{8'd128, 4'd3,  8'd42,  4'd2, 1'b0, 8};

        resetn   = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #2;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_quot", 32'(quotient), 0);
        check("reset_rem",  32'(remainder), 0);
        check("reset_dbz",  32'(dbz), 0);
        #21;
        resetn = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, lat, bacc);
            check($sformatf("v%0d_busy_after_accept", i), 32'(bacc), 1);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_busy_at_done", i), 32'(busy), 0);
            check($sformatf("v%0d_quot", i), 32'(quotient), 32'(vecs[i].exp_q));
            check($sformatf("v%0d_rem", i), 32'(remainder), 32'(vecs[i].exp_r));
            check($sformatf("v%0d_dbz", i), 32'(dbz), 32'(vecs[i].exp_z));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_one_cycle", i), 32'(done), 0);
            check($sformatf("v%0d_quot_held", i), 32'(quotient), 32'(vecs[i].exp_q));
        end

        // Start pulsed mid-operation must be ignored.
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd144;
        divisor  = 4'd12;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        ndone = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) begin
                start    = 1'b1;
                dividend = 8'd99;
                divisor  = 4'd9;
            end
            if (i == 4) start = 1'b0;
            if (done) begin
                ndone++;
                if (lat == 0) begin
                    lat = i;
                    check("ignore_quot", 32'(quotient), 12);
                    check("ignore_rem", 32'(remainder), 0);
                end
            end
        end
        check("ignore_latency", lat, 8);
        check("ignore_done_count", ndone, 1);
        check("ignore_idle_after", 32'(busy), 0);

        // Start raised in the done cycle is accepted immediately.
        run_op(8'd144, 4'd12, lat, bacc);
        check("b2b_first_latency", lat, 8);
        start    = 1'b1;
        dividend = 8'd99;
        divisor  = 4'd9;
        lat      = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                start = 1'b0;
                check("b2b_busy_after_accept", 32'(busy), 1);
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        check("b2b_done_spacing", lat, 9);
        check("b2b_quot", 32'(quotient), 11);
        check("b2b_rem", 32'(remainder), 0);

        // Asynchronous reset during RUN aborts with no done pulse.
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd255;
        divisor  = 4'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_quot", 32'(quotient), 0);
        check("abort_rem", 32'(remainder), 0);
        @(negedge clk);
        resetn = 1'b1;
        ndone  = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        check("abort_idle", 32'(busy), 0);

        // Exhaustive sweep against a reference division and the invariant.
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(8'(a), 4'(b), lat, bacc);
                if (b == 0) begin
                    exp_qi = 255;
                    exp_ri = 0;
                    exp_zi = 1;
                end else begin
                    exp_qi = a / b;
                    exp_ri = a % b;
                    exp_zi = 0;
                end
                check($sformatf("sweep_%0d_%0d", a, b),
                      (lat == 0) ? -1 : (32'(quotient) << 8) | (32'(remainder) << 1) | 32'(dbz),
                      (exp_qi << 8) | (exp_ri << 1) | exp_zi);
                if (b != 0) begin
                    check($sformatf("sweep_inv_%0d_%0d", a, b),
                          32'((32'(quotient) * b + 32'(remainder) == a) && (32'(remainder) < b)),
                          1);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
